// File: rtl/prs_cnt_bank_if.sv
// Bus bundle for the PRS pulse-counter bank: channel inputs, command word,
// SPI snapshot handshake and all registered status outputs.
interface prs_cnt_bank_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       i_ch;
  logic                    i_cmd_valid;
  logic [NUM_CH+1:0]       i_cmd_data;
  logic                    i_snap_req;
  logic                    i_snap_ack;
  logic                    i_snap_abort;
  logic                    o_snap_valid;
  logic [NUM_CH*CNT_W-1:0] o_snap_data;
  logic [NUM_CH-1:0]       o_snap_ovf;
  logic [NUM_CH-1:0]       o_en_mask;
  logic [NUM_CH-1:0]       o_sat_mask;
  logic [NUM_CH-1:0]       o_ovf;

  modport master (
    output i_ch, i_cmd_valid, i_cmd_data, i_snap_req, i_snap_ack, i_snap_abort,
    input  o_snap_valid, o_snap_data, o_snap_ovf, o_en_mask, o_sat_mask, o_ovf
  );

  modport slave (
    input  i_ch, i_cmd_valid, i_cmd_data, i_snap_req, i_snap_ack, i_snap_abort,
    output o_snap_valid, o_snap_data, o_snap_ovf, o_en_mask, o_sat_mask, o_ovf
  );
endinterface

// File: rtl/prs_cnt_bank.sv
// Multi-channel pulse-counter bank with synchronised inputs, wrap/saturate
// modes, sticky overflow flags and a lossless snapshot/delta-clear readout.
module prs_cnt_bank #(
  parameter int NUM_CH      = 16,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_ON_READ = 1
) (
  input logic           i_clk,
  input logic           i_rst_n,
  prs_cnt_bank_if.slave cnt_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               CLR_EN  = (CLR_ON_READ != 0);

  typedef enum logic {
    ST_IDLE,
    ST_LOADED
  } state_e;

  state_e                  state_q;
  logic                    snap_valid_q;
  logic [NUM_CH*CNT_W-1:0] snap_q;
  logic [NUM_CH-1:0]       snap_ovf_q;

  logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]       prev_q;
  logic [NUM_CH-1:0]       en_q;
  logic [NUM_CH-1:0]       sat_q;
  logic [NUM_CH-1:0]       ovf_q;
  logic [NUM_CH-1:0]       ovf_d;
  logic [CNT_W-1:0]        cnt_q [NUM_CH];
  logic [CNT_W-1:0]        cnt_d [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] cnt_flat;

  logic [NUM_CH-1:0]       rise;
  logic [NUM_CH-1:0]       inc;
  logic [1:0]              cmd_op;
  logic [NUM_CH-1:0]       cmd_mask;
  logic [NUM_CH-1:0]       clr_hit;
  logic                    commit;

  assign cmd_op   = cnt_if.i_cmd_data[NUM_CH+1:NUM_CH];
  assign cmd_mask = cnt_if.i_cmd_data[NUM_CH-1:0];
  assign clr_hit  = (cnt_if.i_cmd_valid && cmd_op == 2'b10) ? cmd_mask : '0;
  assign commit   = (state_q == ST_LOADED) && cnt_if.i_snap_ack;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign inc  = rise & en_q;

  // Synchroniser chain and edge-detect history for every channel input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= cnt_if.i_ch;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Enable and saturate masks, loaded from the command word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q  <= '0;
      sat_q <= '0;
    end else if (cnt_if.i_cmd_valid) begin
      if (cmd_op == 2'b00) en_q  <= cmd_mask;
      if (cmd_op == 2'b01) sat_q <= cmd_mask;
    end
  end

  // Per-channel next-state: count, delta-subtract on commit, clear command
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] snap_ch;
    logic [CNT_W-1:0] base;
    logic             sub;
    logic             evt;

    assign snap_ch = snap_q[g*CNT_W +: CNT_W];
    assign sub     = commit && CLR_EN;
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];

    // Subtracting the frozen snapshot keeps pulses that arrived after capture.
    // A saturated channel has lost its true count, so it restarts from this
    // cycle's increment rather than from a meaningless difference.
    always_comb begin
      base     = sub ? (cnt_q[g] - snap_ch) : cnt_q[g];
      evt      = inc[g] && (base == CNT_MAX);
      cnt_d[g] = base;
      if (sub && sat_q[g] && cnt_q[g] == CNT_MAX) begin
        cnt_d[g] = {{(CNT_W-1){1'b0}}, inc[g]};
        evt      = inc[g];
      end else if (inc[g]) begin
        cnt_d[g] = (sat_q[g] && base == CNT_MAX) ? base : base + 1'b1;
      end
      ovf_d[g] = commit ? evt : (ovf_q[g] | evt);
      if (clr_hit[g]) begin
        cnt_d[g] = '0;
        ovf_d[g] = 1'b0;
      end
    end
  end

  // Live counters and sticky overflow flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
    end
  end

  // Snapshot FSM: capture on request, hold until commit or abort
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      snap_valid_q <= 1'b0;
      snap_q       <= '0;
      snap_ovf_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cnt_if.i_snap_req) begin
            snap_q       <= cnt_flat;
            snap_ovf_q   <= ovf_q;
            snap_valid_q <= 1'b1;
            state_q      <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (cnt_if.i_snap_ack || cnt_if.i_snap_abort) begin
            snap_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          snap_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cnt_if.o_snap_valid = snap_valid_q;
  assign cnt_if.o_snap_data  = snap_q;
  assign cnt_if.o_snap_ovf   = snap_ovf_q;
  assign cnt_if.o_en_mask    = en_q;
  assign cnt_if.o_sat_mask   = sat_q;
  assign cnt_if.o_ovf        = ovf_q;

endmodule

// File: tb/tb_prs_cnt_bank.sv
// Directed bench for prs_cnt_bank (16 channels, 8-bit counters, 2 sync stages).
module tb_prs_cnt_bank;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  prs_cnt_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  prs_cnt_bank #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .CLR_ON_READ(1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .cnt_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_ch[ch] = 1'b1;
      tick(2);
      bus.i_ch[ch] = 1'b0;
      tick(2);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] mask);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_data  = {op, mask};
    tick(1);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = '0;
  endtask

  // Read the live counters through a captured-then-aborted snapshot
  task automatic peek(output logic [127:0] d);
    bus.i_snap_req = 1'b1;
    tick(1);
    bus.i_snap_req = 1'b0;
    d = bus.o_snap_data;
    bus.i_snap_abort = 1'b1;
    tick(1);
    bus.i_snap_abort = 1'b0;
  endtask

  logic [127:0] d;
  logic [127:0] exp;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_ch = '0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data = '0;
    bus.i_snap_req = 1'b0;
    bus.i_snap_ack = 1'b0;
    bus.i_snap_abort = 1'b0;

    // Reset state
    tick(3);
    chk("rst_snap_valid", 128'(bus.o_snap_valid), 128'd0);
    chk("rst_snap_data", bus.o_snap_data, 128'd0);
    chk("rst_en_mask", 128'(bus.o_en_mask), 128'd0);
    chk("rst_ovf", 128'(bus.o_ovf), 128'd0);
    rst_n = 1'b1;
    tick(2);

    // Enable all, five pulses on ch3
    cmd(2'b00, 16'hFFFF);
    chk("en_mask_set", 128'(bus.o_en_mask), 128'hFFFF);
    pulse(3, 5);
    peek(d);
    chk("ch3_five", d, 128'h0500_0000);
    chk("ovf_none", 128'(bus.o_ovf), 128'd0);
    chk("abort_clears_valid", 128'(bus.o_snap_valid), 128'd0);

    // Wrap mode: 257 pulses on ch0
    pulse(0, 257);
    peek(d);
    chk("ch0_wrap", d, 128'h0500_0001);
    chk("ovf_wrap", 128'(bus.o_ovf), 128'h0001);

    // Saturate mode on ch0, 300 more pulses
    cmd(2'b01, 16'h0001);
    chk("sat_mask_set", 128'(bus.o_sat_mask), 128'h0001);
    cmd(2'b11, 16'h0000);
    chk("op11_en_keep", 128'(bus.o_en_mask), 128'hFFFF);
    chk("op11_sat_keep", 128'(bus.o_sat_mask), 128'h0001);
    pulse(0, 300);
    peek(d);
    chk("ch0_sat", d, 128'h0500_00FF);
    chk("ovf_sat", 128'(bus.o_ovf), 128'h0001);

    // Commit with delta subtract: ch2 = 10, three more after capture
    pulse(2, 10);
    bus.i_snap_req = 1'b1;
    tick(1);
    bus.i_snap_req = 1'b0;
    chk("cap_valid", 128'(bus.o_snap_valid), 128'd1);
    chk("cap_data", bus.o_snap_data, 128'h050A_00FF);
    chk("cap_ovf", 128'(bus.o_snap_ovf), 128'h0001);
    pulse(2, 3);
    chk("frozen_data", bus.o_snap_data, 128'h050A_00FF);
    bus.i_snap_ack = 1'b1;
    tick(1);
    bus.i_snap_ack = 1'b0;
    chk("commit_valid", 128'(bus.o_snap_valid), 128'd0);
    chk("commit_ovf", 128'(bus.o_ovf), 128'd0);
    peek(d);
    chk("commit_delta", d, 128'h0003_0000);

    // Abort keeps counts; request ignored while loaded
    pulse(1, 7);
    bus.i_snap_req = 1'b1;
    tick(1);
    chk("abort_cap", bus.o_snap_data, 128'h0003_0700);
    pulse(1, 1);
    chk("req_ignored_loaded", bus.o_snap_data, 128'h0003_0700);
    bus.i_snap_req = 1'b0;
    bus.i_snap_abort = 1'b1;
    tick(1);
    bus.i_snap_abort = 1'b0;
    chk("abort_valid", 128'(bus.o_snap_valid), 128'd0);
    pulse(1, 1);
    peek(d);
    chk("abort_recapture", d, 128'h0003_0900);

    // Commit and clear of ch5 in the same cycle as a ch5 increment
    pulse(5, 4);
    pulse(6, 2);
    bus.i_snap_req = 1'b1;
    tick(1);
    bus.i_snap_req = 1'b0;
    exp = '0;
    exp[55:48] = 8'd2;
    exp[47:40] = 8'd4;
    exp[23:16] = 8'd3;
    exp[15:8]  = 8'd9;
    chk("cap2_data", bus.o_snap_data, exp);
    pulse(1, 1);
    bus.i_ch[5] = 1'b1;
    tick(2);
    bus.i_snap_ack  = 1'b1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_data  = {2'b10, 16'h0020};
    tick(1);
    bus.i_snap_ack  = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = '0;
    tick(1);
    bus.i_ch[5] = 1'b0;
    tick(2);
    peek(d);
    chk("clear_wins", d, 128'h0000_0100);
    chk("clear_ovf", 128'(bus.o_ovf), 128'd0);
    chk("clear_en_keep", 128'(bus.o_en_mask), 128'hFFFF);

    // Asynchronous reset while loaded
    pulse(4, 2);
    bus.i_snap_req = 1'b1;
    tick(1);
    bus.i_snap_req = 1'b0;
    chk("pre_rst_valid", 128'(bus.o_snap_valid), 128'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 128'(bus.o_snap_valid), 128'd0);
    chk("arst_data", bus.o_snap_data, 128'd0);
    chk("arst_en", 128'(bus.o_en_mask), 128'd0);
    chk("arst_sat", 128'(bus.o_sat_mask), 128'd0);
    #3;
    rst_n = 1'b1;
    tick(1);
    bus.i_snap_ack = 1'b1;
    tick(1);
    bus.i_snap_ack = 1'b0;
    chk("ack_after_rst", 128'(bus.o_snap_valid), 128'd0);
    pulse(4, 2);
    cmd(2'b00, 16'hFFFF);
    peek(d);
    chk("disabled_no_count", d, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prs_cnt_bank.md
Name: prs_cnt_bank

Overview:
Parametrised multi-channel pulse-counter bank that sits between the PRS channel inputs and the SPI slave TX/RX buffers. Replaces per-readout "reset after read" with lossless delta-clear: a snapshot is frozen for SPI transfer and subtracted from the live counters only once the transfer is committed. Adds per-channel input synchronisation, wrap or saturate mode, sticky overflow flags and an opcode-based command word. Runs entirely on i_clk; no divided clock.

Parameters:
NUM_CH, 16, number of counter channels (1..32)
CNT_W, 8, counter width in bits (2..32)
SYNC_STAGES, 2, synchroniser flops per channel input (>=2)
CLR_ON_READ, 1, 1 = subtract snapshot from counters on commit; 0 = counters free-run, commit only clears overflow flags

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active-low
i_ch  in  NUM_CH  asynchronous pulse inputs, one per channel
i_cmd_valid  in  1  one-cycle strobe, command word valid (from SPI RX valid)
i_cmd_data  in  NUM_CH+2  [NUM_CH+1:NUM_CH] opcode, [NUM_CH-1:0] channel mask
i_snap_req  in  1  SPI requests TX data (level or pulse)
i_snap_ack  in  1  SPI transfer started; commit snapshot
i_snap_abort  in  1  SPI went idle without transfer; discard snapshot
o_snap_valid  out  1  snapshot held and valid (to SPI TX valid)
o_snap_data  out  NUM_CH*CNT_W  snapshot counts, channel i at [CNT_W*(i+1)-1 : CNT_W*i]
o_snap_ovf  out  NUM_CH  overflow flags captured with snapshot
o_en_mask  out  NUM_CH  current enable mask
o_sat_mask  out  NUM_CH  current saturate-mode mask
o_ovf  out  NUM_CH  live sticky overflow flags

Behaviour:
- Reset (async, i_rst_n low): counters, synchronisers, edge registers, masks, o_ovf, o_snap_data, o_snap_ovf = 0; o_snap_valid = 0; FSM = IDLE.
- Input path: i_ch[i] -> SYNC_STAGES flops -> rising-edge detect. Increment inc[i] = edge & o_en_mask[i]. Input rise to counter change: SYNC_STAGES+1 cycles. Pulses must be >= 2 i_clk high and low; shorter ones are not guaranteed.
- Counting: wrap mode (sat_mask[i]=0): max+1 -> 0, set o_ovf[i]. Saturate mode: at max stays at max, inc sets o_ovf[i]. o_ovf is sticky.
- Commands, applied on the cycle after i_cmd_valid:
  - opcode 00: en_mask <= mask.
  - opcode 01: sat_mask <= mask.
  - opcode 10: counters and o_ovf of masked channels <= 0. Same-cycle inc on those channels is dropped.
  - opcode 11: ignored.
  - A mask change affects increments from the next cycle.
- FSM IDLE/LOADED:
  - IDLE & i_snap_req: o_snap_data <= live counters (pre-increment value this cycle); o_snap_ovf <= o_ovf; o_snap_valid = 1 next cycle; -> LOADED.
  - LOADED: o_snap_data/o_snap_ovf frozen; i_snap_req ignored.
  - LOADED & i_snap_ack (commit): if CLR_ON_READ, counter[i] <= (counter[i] - snap[i]) + inc[i] mod 2^CNT_W. A channel in saturate mode whose counter == max <= inc[i]. Always o_ovf[i] <= inc-overflow of this cycle only (flags captured in the snapshot are cleared). o_snap_valid <= 0; -> IDLE.
  - LOADED & i_snap_abort & !i_snap_ack: no counter or flag change; o_snap_valid <= 0; -> IDLE.
  - ack and abort together: ack wins.
- Simultaneous events:
  - Commit plus opcode-10 clear: clear wins for masked channels.
  - Commit plus opcode 00/01: both apply.
- Counts arriving between capture and commit are never lost (delta subtract).
- Reset mid-LOADED: snapshot discarded; all state returns to reset values.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, en_mask=0xFFFF via cmd opcode 00, 5 pulses on ch3 -> counter3=5 after SYNC_STAGES+1 cycles past last edge; other channels 0; o_ovf=0.
- CNT_W=8 wrap mode, 257 pulses on ch0 -> counter0=1, o_ovf[0]=1; set sat_mask bit0, 300 pulses -> counter0=255, o_ovf[0]=1.
- Counter2=10; snap_req -> o_snap_valid=1, snap ch2=10; 3 more pulses; snap_ack -> counter2=3, o_snap_valid=0, o_ovf cleared.
- Counter1=7; snap_req then snap_abort -> counter1 unchanged (7 plus any new pulses), o_snap_valid=0, FSM IDLE; next snap_req re-captures the current value.
- Commit and opcode-10 clear with mask bit5 in the same cycle, with an edge on ch5 -> counter5=0; other channels get delta-subtracted values.
- Assert i_rst_n low while LOADED -> o_snap_valid=0, all counters/masks 0 immediately (async); i_snap_ack after release has no effect.
